// File: rtl/grad_pkg.sv
// Shared types and sizes for the gradient (Sobel) stage of the edge detector.
// Optional direction output is controlled by the GRAD_DIR_EN macro (see sobel_kernel).
package grad_pkg;

    localparam int ROW_W  = 16;
    localparam int GRAD_W = ROW_W - 2;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        DIR_0,
        DIR_45,
        DIR_90,
        DIR_135
    } grad_dir_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel: magnitude (|Gx|+|Gy|)>>SHIFT and a 2-bit direction code.
// Direction comparators exist only when GRAD_DIR_EN is defined; otherwise dir_o is 0.
module sobel_kernel
    import grad_pkg::*;
#(
    parameter int SHIFT = 3
) (
    input  pixel_t [2:0][2:0] win_i,
    output logic   [7:0]      mag_o,
    output grad_dir_t         dir_o
);

    logic signed [10:0] s [3][3];
    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic        [10:0] ax;
    logic        [10:0] ay;
    logic        [11:0] sum;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                s[r][c] = signed'({3'b000, win_i[r][c]});
            end
        end
    end

    assign gx = (s[0][2] + s[1][2] + s[1][2] + s[2][2]) - (s[0][0] + s[1][0] + s[1][0] + s[2][0]);
    assign gy = (s[2][0] + s[2][1] + s[2][1] + s[2][2]) - (s[0][0] + s[0][1] + s[0][1] + s[0][2]);

    assign ax  = gx[10] ? 11'(-gx) : 11'(gx);
    assign ay  = gy[10] ? 11'(-gy) : 11'(gy);
    assign sum = {1'b0, ax} + {1'b0, ay};
    // Sum never exceeds 2040, so the shifted value always fits 8 bits.
    assign mag_o = 8'(sum >> SHIFT);

`ifdef GRAD_DIR_EN
    always_comb begin
        if ({ay, 1'b0} <= {1'b0, ax}) begin
            dir_o = DIR_0;
        end else if ({ax, 1'b0} <= {1'b0, ay}) begin
            dir_o = DIR_90;
        end else if (gx[10] == gy[10]) begin
            dir_o = DIR_45;
        end else begin
            dir_o = DIR_135;
        end
    end
`else
    assign dir_o = DIR_0;
`endif

endmodule

// File: rtl/gradient_controller.sv
// Sliding 3-row window over blurred rows; one Sobel column per cycle, grad_final when done.
// Direction output is built only with GRAD_DIR_EN defined; otherwise grad_dir reads 0.
module gradient_controller
    import grad_pkg::*;
#(
    parameter int ROW_W = 16,
    parameter int SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blur_final,
    input  logic                   row_first,
    input  logic [ROW_W-1:0][7:0]  blur_row,
    output logic [ROW_W-3:0][7:0]  grad_out,
    output logic [ROW_W-3:0][1:0]  grad_dir,
    output logic                   grad_final,
    output logic                   busy,
    output logic                   overrun
);

    localparam int GW = ROW_W - 2;
    localparam int CW = $clog2(ROW_W);

    state_t                  state_q;
    logic [ROW_W-1:0][7:0]   win0_q;
    logic [ROW_W-1:0][7:0]   win1_q;
    logic [ROW_W-1:0][7:0]   win2_q;
    logic [CW-1:0]           col_q;
    logic [GW-1:0][7:0]      grad_q;
    logic [GW-1:0][1:0]      dir_q;
    logic                    final_q;
    logic                    busy_q;
    logic                    ovr_q;

    pixel_t [2:0][2:0]       win;
    logic   [7:0]            mag;
    grad_dir_t               dir;

    // The single kernel is time-multiplexed across columns by col_q.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            win[0][c] = win0_q[col_q + CW'(c)];
            win[1][c] = win1_q[col_q + CW'(c)];
            win[2][c] = win2_q[col_q + CW'(c)];
        end
    end

    sobel_kernel #(
        .SHIFT (SHIFT)
    ) u_sobel (
        .win_i (win),
        .mag_o (mag),
        .dir_o (dir)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            win0_q  <= '0;
            win1_q  <= '0;
            win2_q  <= '0;
            col_q   <= '0;
            grad_q  <= '0;
            dir_q   <= '0;
            final_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            final_q <= 1'b0;
            if (blur_final && state_q != S_IDLE) begin
                ovr_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (blur_final) begin
                        // First row of a frame replicates into all three rows (top border).
                        if (row_first) begin
                            win0_q <= blur_row;
                            win1_q <= blur_row;
                        end else begin
                            win0_q <= win1_q;
                            win1_q <= win2_q;
                        end
                        win2_q  <= blur_row;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    grad_q[col_q] <= mag;
                    dir_q[col_q]  <= dir;
                    if (col_q == CW'(GW - 1)) begin
                        final_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grad_out   = grad_q;
    assign grad_dir   = dir_q;
    assign grad_final = final_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;

endmodule
